// File: rtl/hmi_pkg.sv
// ============================================================================
// Module      : hmi_pkg
// Description : Shared state encoding, ASCII constants and helper functions
//               for the HMI numeric-frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hmi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_CONV  = 3'd2,
        ST_NAME  = 3'd3,
        ST_NUM   = 3'd4,
        ST_TERM  = 3'd5
    } hmi_state_e;

    localparam logic [7:0]  HMI_CH_N     = 8'h6E;   // 'n'
    localparam logic [7:0]  HMI_CH_DOT   = 8'h2E;   // '.'
    localparam logic [7:0]  HMI_CH_ZERO  = 8'h30;   // '0'
    localparam logic [31:0] HMI_STR_VAL  = "val=";
    localparam logic [7:0]  HMI_TERM     = 8'hFF;
    localparam int          HMI_TERM_CNT = 3;

    // Largest value representable in the given number of decimal digits.
    function automatic logic [63:0] hmi_max_val(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    // Byte at position pos of the "n<idx>.val=" prefix.
    function automatic logic [7:0] hmi_name_byte(input logic [3:0] pos,
                                                 input logic       two,
                                                 input logic [3:0] tens,
                                                 input logic [3:0] ones);
        logic [3:0] k;
        logic [7:0] b;
        k = (two && pos >= 4'd2) ? pos - 4'd1 : pos;
        b = HMI_TERM;
        if (pos == 4'd0) begin
            b = HMI_CH_N;
        end else if (two && pos == 4'd1) begin
            b = HMI_CH_ZERO + {4'h0, tens};
        end else begin
            case (k)
                4'd1:                b = HMI_CH_ZERO + {4'h0, ones};
                4'd2:                b = HMI_CH_DOT;
                4'd3, 4'd4, 4'd5, 4'd6:
                                     b = HMI_STR_VAL[(6 - int'(k)) * 8 +: 8];
                default:             b = HMI_TERM;
            endcase
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hmi_frame_tx_if.sv
// ============================================================================
// Module      : hmi_frame_tx_if
// Description : Valid/ready byte stream from the frame transmitter to the UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hmi_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/hmi_bin2dec.sv
// ============================================================================
// Module      : hmi_bin2dec
// Description : Sequential shift-add-3 binary to BCD converter, one bit per
//               cycle; done pulses DATA_W+1 cycles after start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hmi_bin2dec
    import hmi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [DATA_W-1:0]     bin,
    output logic      [4*DIGITS-1:0]   bcd,
    output logic      [3:0]            ndig,
    output logic                       ovf,
    output logic                       done
);

    localparam int          SH_W  = 4 * DIGITS + DATA_W;
    localparam int          CNT_W = $clog2(DATA_W + 1);
    localparam logic [63:0] MAXV  = hmi_max_val(DIGITS);

    logic [SH_W-1:0]  sh_q,  sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [SH_W-1:0]  adj;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        adj    = sh_q;
        if (start) begin
            sh_d  = {{(4*DIGITS){1'b0}}, bin};
            cnt_d = CNT_W'(DATA_W);
            run_d = 1'b1;
            ovf_d = (64'(bin) > MAXV);
        end else if (run_q) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (sh_q[DATA_W + 4*d +: 4] >= 4'd5) begin
                    adj[DATA_W + 4*d +: 4] = sh_q[DATA_W + 4*d +: 4] + 4'd3;
                end
            end
            sh_d  = {adj[SH_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    // Digits above the most significant non-zero one are leading zeros.
    always_comb begin
        ndig = 4'd1;
        for (int d = 1; d < DIGITS; d++) begin
            if (sh_q[DATA_W + 4*d +: 4] != 4'd0) begin
                ndig = 4'(d + 1);
            end
        end
    end

    assign bcd  = sh_q[SH_W-1 -: 4*DIGITS];
    assign ovf  = ovf_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/hmi_frame_tx.sv
// ============================================================================
// Module      : hmi_frame_tx
// Description : Periodic multi-channel Nextion "n<i>.val=<dec>" frame sender.
//               Optional macro HMI_SKIP_UNCHANGED_EN skips unchanged channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hmi_frame_tx
    import hmi_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 16,
    parameter int DIGITS = 5,
    parameter int PERIOD = 5000
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic [NUM_CH*DATA_W-1:0] ch_data,
    hmi_frame_tx_if.master                tx,
    output logic                          busy,
    output logic                          sweep_done,
    output logic                          sat
);

    localparam int                 IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                 CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    hmi_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [3:0]            tens_q, ones_q;
    logic [3:0]            pos_q;
    logic [4*DIGITS-1:0]   digits_q;
    logic [3:0]            ndig_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q, busy_q, done_q, sat_q;

    logic                  conv_start, conv_ovf, conv_done;
    logic [4*DIGITS-1:0]   conv_bcd;
    logic [3:0]            conv_ndig;
    logic [DATA_W-1:0]     ch_cur;
    logic                  skip, accept, two_dig, ch_end;
    logic [3:0]            name_last, sel_first, sel_next;
    logic [7:0]            byte_first, byte_next;

    assign ch_cur     = ch_data[int'(idx_q) * DATA_W +: DATA_W];
    assign accept     = tx_valid_q && tx.tx_ready;
    assign two_dig    = (tens_q != 4'd0);
    assign name_last  = two_dig ? 4'd7 : 4'd6;
    assign sel_first  = ndig_q - 4'd1;
    assign sel_next   = pos_q - 4'd1;
    assign byte_first = HMI_CH_ZERO + {4'h0, digits_q[int'(sel_first) * 4 +: 4]};
    assign byte_next  = HMI_CH_ZERO + {4'h0, digits_q[int'(sel_next) * 4 +: 4]};
    assign conv_start = (state_q == ST_LATCH) && !skip;
    assign ch_end     = ((state_q == ST_LATCH) && skip) ||
                        ((state_q == ST_TERM) && accept &&
                         (pos_q == 4'(HMI_TERM_CNT - 1)));

`ifdef HMI_SKIP_UNCHANGED_EN
    logic [DATA_W-1:0] last_q [NUM_CH];
    logic [NUM_CH-1:0] last_vld_q;
    logic [DATA_W-1:0] hold_q;

    assign skip = last_vld_q[idx_q] && (ch_cur == last_q[idx_q]);

    always_ff @(posedge clk) begin
        if (conv_start) begin
            hold_q <= ch_cur;
        end
        if (ch_end && state_q == ST_TERM) begin
            last_q[idx_q] <= hold_q;
        end
    end

    // Valid bits alone carry reset so the first sweep always sends everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld_q <= '0;
        end else if (ch_end && state_q == ST_TERM) begin
            last_vld_q[idx_q] <= 1'b1;
        end
    end
`else
    assign skip = 1'b0;
`endif

    hmi_bin2dec #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2dec (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (ch_cur),
        .bcd   (conv_bcd),
        .ndig  (conv_ndig),
        .ovf   (conv_ovf),
        .done  (conv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            pos_q      <= 4'd0;
            digits_q   <= '0;
            ndig_q     <= 4'd1;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cnt_q == CNT_W'(PERIOD - 1)) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tens_q  <= 4'd0;
                        ones_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LATCH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    state_q <= ST_CONV;
                end
                ST_CONV: begin
                    if (conv_done) begin
                        digits_q   <= conv_ovf ? NINES : conv_bcd;
                        ndig_q     <= conv_ovf ? 4'(DIGITS) : conv_ndig;
                        sat_q      <= sat_q | conv_ovf;
                        pos_q      <= 4'd0;
                        tx_data_q  <= HMI_CH_N;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_NAME;
                    end
                end
                ST_NAME: begin
                    if (accept) begin
                        if (pos_q == name_last) begin
                            pos_q     <= sel_first;
                            tx_data_q <= byte_first;
                            state_q   <= ST_NUM;
                        end else begin
                            pos_q     <= pos_q + 4'd1;
                            tx_data_q <= hmi_name_byte(pos_q + 4'd1, two_dig,
                                                       tens_q, ones_q);
                        end
                    end
                end
                ST_NUM: begin
                    if (accept) begin
                        if (pos_q == 4'd0) begin
                            tx_data_q <= HMI_TERM;
                            state_q   <= ST_TERM;
                        end else begin
                            pos_q     <= sel_next;
                            tx_data_q <= byte_next;
                        end
                    end
                end
                ST_TERM: begin
                    if (accept) begin
                        pos_q     <= pos_q + 4'd1;
                        tx_data_q <= HMI_TERM;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Channel finished (sent or skipped): move on or close the sweep.
            if (ch_end) begin
                tx_valid_q <= 1'b0;
                pos_q      <= 4'd0;
                if (idx_q == LAST_IDX) begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end else begin
                    idx_q   <= idx_q + IDX_W'(1);
                    if (ones_q == 4'd9) begin
                        ones_q <= 4'd0;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        ones_q <= ones_q + 4'd1;
                    end
                    state_q <= ST_LATCH;
                end
            end
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign sweep_done  = done_q;
    assign sat         = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_hmi_frame_tx.sv
// ============================================================================
// Module      : tb_hmi_frame_tx
// Description : Scoreboard bench for hmi_frame_tx (12 channels, 4 digits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hmi_frame_tx;

    localparam int NUM_CH    = 12;
    localparam int DATA_W    = 17;
    localparam int DIGITS    = 4;
    localparam int PERIOD    = 20;
    localparam int MAXV      = 9999;
    localparam int SWEEP_TOK = 256;
    localparam int LATENCY   = PERIOD + DATA_W + 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic                     busy, sweep_done, sat;
    logic                     rand_ready = 1'b0;

    int vectors    = 0;
    int miscompares = 0;
    int exp_q[$];
    int vals[NUM_CH];
`ifdef HMI_SKIP_UNCHANGED_EN
    int last_sent[NUM_CH];
    bit last_vld[NUM_CH];
`endif

    hmi_frame_tx_if tx_if ();

    hmi_frame_tx #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DIGITS (DIGITS),
        .PERIOD (PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_data    (ch_data),
        .tx         (tx_if.master),
        .busy       (busy),
        .sweep_done (sweep_done),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(int'(s[i]));
    endtask

    task automatic push_frame(input int idx, input int v);
        int shown;
        shown = (v > MAXV) ? MAXV : v;
        push_str($sformatf("n%0d.val=%0d", idx, shown));
        for (int t = 0; t < 3; t++) exp_q.push_back(255);
    endtask

    // Drive the channel bus and queue the bytes one full sweep must produce.
    task automatic push_sweep();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i*DATA_W +: DATA_W] = vals[i][DATA_W-1:0];
`ifdef HMI_SKIP_UNCHANGED_EN
            if (last_vld[i] && last_sent[i] == vals[i]) continue;
            last_vld[i]  = 1'b1;
            last_sent[i] = vals[i];
`endif
            push_frame(i, vals[i]);
        end
        exp_q.push_back(SWEEP_TOK);
    endtask

    task automatic wait_sweep(input string name);
        int n;
        n = 0;
        while (!sweep_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, sweep_done, 1);
        chk({name, "_busy_idle"}, busy, 0);
        @(negedge clk);
    endtask

    task automatic measure_latency(input string name);
        int n;
        n = 0;
        while (!tx_if.tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_first_valid_cycles"}, n, LATENCY);
        chk({name, "_busy_active"}, busy, 1);
    endtask

    // Ready driver: full rate or roughly 30% duty.
    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_if.tx_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: every accepted byte and every sweep_done pops the scoreboard.
    initial begin
        bit         pend;
        logic [7:0] pdata;
        int         e;
        pend  = 1'b0;
        pdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("stall_valid_hold", tx_if.tx_valid, 1);
                    chk("stall_data_hold", tx_if.tx_data, pdata);
                end
                if (tx_if.tx_valid && tx_if.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_byte: got 0x%02h, expected none", tx_if.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", tx_if.tx_data, e);
                    end
                end
                if (sweep_done) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_sweep_done: got pulse, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("sweep_done_position", SWEEP_TOK, e);
                    end
                end
                pend  = tx_if.tx_valid && !tx_if.tx_ready;
                pdata = tx_if.tx_data;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vals = '{1234, 0, 9999, 5, 42, 100, 9, 1000, 65, 10, 3, 7};
`ifdef HMI_SKIP_UNCHANGED_EN
        for (int i = 0; i < NUM_CH; i++) last_vld[i] = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", tx_if.tx_valid, 0);
        chk("rst_tx_data", tx_if.tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_sat", sat, 0);

        // Sweep 1: zero, 9999 boundary, one- and two-digit indices.
        push_sweep();
        rst_n = 1'b1;
        measure_latency("s1");
        wait_sweep("s1");
        chk("s1_sat", sat, 0);

        // Sweep 2: values above 9999 saturate.
        vals[2] = 70000;
        vals[4] = 10000;
        push_sweep();
        wait_sweep("s2");
        chk("s2_sat", sat, 1);

        // Sweep 3: in-range values under random back-pressure; sat is sticky.
        vals[1] = 77;
        vals[2] = 5;
        vals[4] = 10;
        rand_ready = 1'b1;
        push_sweep();
        wait_sweep("s3");
        chk("s3_sat_sticky", sat, 1);
        rand_ready = 1'b0;

        // Sweep 4: reset while the first terminator is on the bus.
        vals[0] = 4321;
        push_sweep();
        n = 0;
        while (!(tx_if.tx_valid && tx_if.tx_data == 8'hFF) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("s4_reached_term", tx_if.tx_data, 8'hFF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid", tx_if.tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_data", tx_if.tx_data, 0);
        exp_q.delete();
`ifdef HMI_SKIP_UNCHANGED_EN
        for (int i = 0; i < NUM_CH; i++) last_vld[i] = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("midrst_sat", sat, 0);

        // Sweep 5: fresh start after reset, the aborted frame is not resumed.
        push_sweep();
        rst_n = 1'b1;
        measure_latency("s5");
        wait_sweep("s5");
        chk("s5_sat", sat, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
